// File: rtl/neuron_prog_sequencer.sv
// Per-neuron reset pulse and serial weight programming sequencer.
// Optional feature: SEQ_BROADCAST_EN makes the all-ones index a broadcast.
module neuron_prog_sequencer #(
  parameter  int NEURONS    = 24,
  parameter  int MEMORY     = 8,
  parameter  int RST_CYCLES = 2,
  localparam int IDXW       = $clog2(NEURONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [IDXW-1:0]    cmd_index,
  input  logic [MEMORY-1:0]  cmd_pattern,
  output logic [NEURONS-1:0] nrst_vec,
  output logic               control,
  output logic               prog_data,
  output logic [NEURONS-1:0] prog_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int BCW = $clog2(MEMORY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [RCW-1:0]     rcnt_q, rcnt_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               op_q, op_d;
  logic               bc_q, bc_d;
  logic [MEMORY-1:0]  pat_q, pat_d;

  logic [NEURONS-1:0] nrst_q, nrst_d;
  logic [NEURONS-1:0] sel_q, sel_d;
  logic               ctl_q, ctl_d;
  logic               pdat_q, pdat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;

  logic               is_bc;
  logic               bad_idx;
  logic [NEURONS-1:0] onehot;

`ifdef SEQ_BROADCAST_EN
  assign is_bc = (cmd_index == {IDXW{1'b1}});
`else
  assign is_bc = 1'b0;
`endif
  assign bad_idx = !is_bc && (int'(cmd_index) >= NEURONS);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    op_d    = op_q;
    bc_d    = bc_q;
    pat_d   = pat_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          if (bad_idx) begin
            err_d = 1'b1;
          end else begin
            state_d = RST;
            rcnt_d  = '0;
            idx_d   = cmd_index;
            op_d    = cmd_op;
            bc_d    = is_bc;
            pat_d   = cmd_pattern;
          end
        end
      end
      RST: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = op_q ? LOAD : DONE;
          bit_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      LOAD: begin
        // pattern shifts so bit 0 always holds the bit being driven
        if (bit_q == BCW'(MEMORY - 1)) begin
          state_d = DONE;
        end else begin
          bit_d = bit_q + 1'b1;
          pat_d = pat_q >> 1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they are registered.
  always_comb begin
    onehot = NEURONS'(1) << idx_d;
    nrst_d = '1;
    sel_d  = '0;
    ctl_d  = 1'b0;
    pdat_d = 1'b0;
    if (state_d == RST) begin
      nrst_d = bc_d ? '0 : ~onehot;
    end
    if (state_d == LOAD) begin
      ctl_d  = 1'b1;
      sel_d  = bc_d ? '1 : onehot;
      pdat_d = pat_d[0];
    end
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      op_q    <= 1'b0;
      bc_q    <= 1'b0;
      pat_q   <= '0;
      nrst_q  <= '0;
      sel_q   <= '0;
      ctl_q   <= 1'b0;
      pdat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      bc_q    <= bc_d;
      pat_q   <= pat_d;
      nrst_q  <= nrst_d;
      sel_q   <= sel_d;
      ctl_q   <= ctl_d;
      pdat_q  <= pdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign nrst_vec  = nrst_q;
  assign control   = ctl_q;
  assign prog_data = pdat_q;
  assign prog_sel  = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_neuron_prog_sequencer.sv
// Directed bench for neuron_prog_sequencer.
// Covers broadcast only when SEQ_BROADCAST_EN is defined.
module tb_neuron_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [4:0]  cmd_index;
  logic [7:0]  cmd_pattern;
  logic [23:0] nrst_vec;
  logic        control;
  logic        prog_data;
  logic [23:0] prog_sel;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  neuron_prog_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_index   (cmd_index),
    .cmd_pattern (cmd_pattern),
    .nrst_vec    (nrst_vec),
    .control     (control),
    .prog_data   (prog_data),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [4:0] idx,
                       input logic [7:0] pat);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_index   = idx;
    cmd_pattern = pat;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 1'b0;
    cmd_index   = '0;
    cmd_pattern = '0;
    tick();
    tick();
    chk("rst_nrst", 32'(nrst_vec), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    rst_n = 1'b1;
    tick();
    chk("idle_nrst", 32'(nrst_vec), 32'hFFFFFF);
    chk("idle_ready", 32'(cmd_ready), 32'h1);
    chk("idle_sel", 32'(prog_sel), 32'h0);

    // program neuron 5 with 0xA5
    pat = 8'hA5;
    issue(1'b1, 5'd5, pat);
    for (int c = 0; c < 2; c++) begin
      chk("p5_nrst", 32'(nrst_vec), 32'hFFFFDF);
      chk("p5_busy", 32'(busy), 32'h1);
      chk("p5_ctl_rst", 32'(control), 32'h0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk("p5_ctl", 32'(control), 32'h1);
      chk("p5_sel", 32'(prog_sel), 32'h000020);
      chk("p5_data", 32'(prog_data), 32'(pat[k]));
      chk("p5_nrst_ld", 32'(nrst_vec), 32'hFFFFFF);
      tick();
    end
    chk("p5_done", 32'(done), 32'h1);
    chk("p5_ctl_dn", 32'(control), 32'h0);
    chk("p5_rdy_dn", 32'(cmd_ready), 32'h0);
    tick();
    chk("p5_ready", 32'(cmd_ready), 32'h1);
    chk("p5_done0", 32'(done), 32'h0);

    // reset-only on neuron 23
    issue(1'b0, 5'd23, 8'hFF);
    for (int c = 0; c < 2; c++) begin
      chk("r23_nrst", 32'(nrst_vec), 32'h7FFFFF);
      chk("r23_ctl", 32'(control), 32'h0);
      tick();
    end
    chk("r23_done", 32'(done), 32'h1);
    chk("r23_ctl_dn", 32'(control), 32'h0);
    tick();
    chk("r23_ready", 32'(cmd_ready), 32'h1);

    // out-of-range index
    issue(1'b1, 5'd26, 8'h3C);
    chk("e26_err", 32'(err), 32'h1);
    chk("e26_busy", 32'(busy), 32'h0);
    chk("e26_nrst", 32'(nrst_vec), 32'hFFFFFF);
    chk("e26_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("e26_err0", 32'(err), 32'h0);
    chk("e26_busy0", 32'(busy), 32'h0);

`ifdef SEQ_BROADCAST_EN
    issue(1'b1, 5'd31, 8'h5A);
    for (int c = 0; c < 2; c++) begin
      chk("bc_nrst", 32'(nrst_vec), 32'h0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk("bc_sel", 32'(prog_sel), 32'hFFFFFF);
      chk("bc_ctl", 32'(control), 32'h1);
      tick();
    end
    chk("bc_done", 32'(done), 32'h1);
    tick();
`else
    issue(1'b1, 5'd31, 8'h5A);
    chk("i31_err", 32'(err), 32'h1);
    chk("i31_busy", 32'(busy), 32'h0);
    tick();
`endif

    // global reset during the 4th LOAD cycle
    issue(1'b1, 5'd3, 8'h0F);
    tick();
    tick();
    for (int k = 0; k < 3; k++) tick();
    chk("ab_ctl_pre", 32'(control), 32'h1);
    chk("ab_data_pre", 32'(prog_data), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("ab_nrst", 32'(nrst_vec), 32'h0);
    chk("ab_ctl", 32'(control), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_ready", 32'(cmd_ready), 32'h0);
    tick();
    chk("ab_done2", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ab_idle_nrst", 32'(nrst_vec), 32'hFFFFFF);
    chk("ab_idle_rdy", 32'(cmd_ready), 32'h1);
    chk("ab_idle_done", 32'(done), 32'h0);

    // new command completes after the abort
    issue(1'b0, 5'd0, 8'h00);
    chk("nc_nrst", 32'(nrst_vec), 32'hFFFFFE);
    tick();
    chk("nc_nrst2", 32'(nrst_vec), 32'hFFFFFE);
    tick();
    chk("nc_done", 32'(done), 32'h1);
    tick();
    chk("nc_ready", 32'(cmd_ready), 32'h1);
    chk("nc_nrst3", 32'(nrst_vec), 32'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
